// File: rtl/pci_arb_pkg.sv
// Shared types and default parameters for the FIFO-ordered PCI bus arbiter.
package pci_arb_pkg;

  // Grant sequencer states: waiting for work, master holds GNT#, bus in use.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  // Default configuration of the arbiter.
  localparam int DEF_N_MASTERS   = 8;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_GNT_TIMEOUT = 16;

endpackage

// File: rtl/pci_idx_fifo.sv
// Synchronous FIFO of master indices. The head entry is visible in the same
// cycle it becomes valid so the grant sequencer can decide without an extra
// read cycle. A push into a full FIFO is accepted only alongside a pop.
module pci_idx_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pci_fifo_arbiter.sv
// First-in-first-out PCI bus arbiter. New requesters are queued by index in
// arrival order (lowest index first when several arrive together); a grant
// sequencer pops the head, drives a single active-low GNT# and follows
// FRAME#/IRDY# to learn when the bus is free again.
module pci_fifo_arbiter
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS   = DEF_N_MASTERS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  parameter int IDX_W       = $clog2(N_MASTERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic                         gnt_valid,
  output logic [IDX_W-1:0]             gnt_idx,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         q_full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(GNT_TIMEOUT + 1);

  arb_state_t           state_reg;
  arb_state_t           state_next;
  logic [TMR_W-1:0]     timer_reg;
  logic [TMR_W-1:0]     timer_next;
  logic [IDX_W-1:0]     gnt_idx_reg;
  logic [IDX_W-1:0]     gnt_idx_next;
  logic [N_MASTERS-1:0] gnt_n_reg;
  logic [N_MASTERS-1:0] gnt_n_next;
  logic                 gnt_valid_reg;
  logic                 gnt_valid_next;
  logic [N_MASTERS-1:0] pending_reg;
  logic [N_MASTERS-1:0] pending_next;

  logic [N_MASTERS-1:0] candidates;
  logic [IDX_W-1:0]     push_idx;
  logic                 push;
  logic                 pop;
  logic [IDX_W-1:0]     head_idx;
  logic                 q_empty;
  logic                 clr_en;
  logic [IDX_W-1:0]     clr_idx;

  genvar gi;

  // Masters asking for the bus that are not already queued or being served.
  assign candidates = ~req_n & ~pending_reg;

  // Lowest-index candidate wins the single push slot of this cycle.
  always_comb begin
    push_idx = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        push_idx = IDX_W'(i);
      end
    end
  end

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = (|candidates) && (!q_full || pop);

  pci_idx_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_idx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_idx),
    .pop       (pop),
    .head      (head_idx),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // State register: sequencer state, grant timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      gnt_idx_reg   <= '0;
      gnt_n_reg     <= '1;
      gnt_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_n_reg     <= gnt_n_next;
      gnt_valid_reg <= gnt_valid_next;
    end
  end

  // Next-state logic: pop/discard in IDLE, release conditions in GRANT
  // (FRAME# first, then withdrawal, then timeout), bus-idle wait in BUSY.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    gnt_idx_next = gnt_idx_reg;
    pop          = 1'b0;
    clr_en       = 1'b0;
    clr_idx      = gnt_idx_reg;
    case (state_reg)
      IDLE: begin
        if (!q_empty) begin
          pop = 1'b1;
          if (!req_n[head_idx]) begin
            gnt_idx_next = head_idx;
            timer_next   = '0;
            state_next   = GRANT;
          end else begin
            // Request was withdrawn while queued: drop the stale entry.
            clr_en  = 1'b1;
            clr_idx = head_idx;
          end
        end
      end
      GRANT: begin
        if (!frame_n) begin
          clr_en     = 1'b1;
          state_next = BUSY;
        end else if (req_n[gnt_idx_reg]) begin
          clr_en     = 1'b1;
          state_next = IDLE;
        end else if (timer_reg == TMR_W'(GNT_TIMEOUT - 1)) begin
          clr_en     = 1'b1;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      BUSY: begin
        if (frame_n && irdy_n) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: grant is valid exactly while the next state is GRANT.
  always_comb begin
    gnt_valid_next = (state_next == GRANT);
  end

  // One-cold GNT# decode of the granted index.
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_gnt_decode
      assign gnt_n_next[gi] = !(gnt_valid_next && (gnt_idx_next == IDX_W'(gi)));
    end
  endgenerate

  // Pending bits: set on enqueue, cleared when service ends or entry is dropped.
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_pending
      assign pending_next[gi] = (pending_reg[gi] | (push && (push_idx == IDX_W'(gi))))
                              & ~(clr_en && (clr_idx == IDX_W'(gi)));
    end
  endgenerate

  // Pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign gnt_n     = gnt_n_reg;
  assign gnt_valid = gnt_valid_reg;
  assign gnt_idx   = gnt_idx_reg;

endmodule
